rxpu: RTL

- Receive packet processing unit for the USB device endpoint; the receive-side counterpart of the transmit packet processor.
- Consumes bytes from the byte receiver, then validates the PID, token address/endpoint and data CRC16.
- Forwards OUT/DATA payload bytes to the RX FIFO.
- Answers IN tokens by pulsing send_data or send_nak to the TX side, and stays idle while the TX side is transmitting.

---
 rtl/usb_pkg.sv | 46 ++++
 rtl/rx_crc16.sv | 26 ++
 rtl/rxpu.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions: PID encodings, rxpu state encoding, CRC16 constants
// and a byte-wide CRC16 update usable by both receive and transmit paths.
package usb_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 16;

  localparam logic [CRC_W-1:0] CRC16_POLY  = 16'h8005;
  localparam logic [CRC_W-1:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [CRC_W-1:0] CRC_RESIDUE = 16'h800D;

  // Full PID byte: {~pid[3:0], pid[3:0]}
  typedef enum logic [BYTE_W-1:0] {
    PID_OUT   = 8'hE1,
    PID_IN    = 8'h69,
    PID_DATA0 = 8'hC3,
    PID_DATA1 = 8'h4B,
    PID_ACK   = 8'hD2,
    PID_NAK   = 8'h5A
  } pid_e;

  typedef enum logic [2:0] {
    IDLE,
    RCV_PID,
    TOKEN1,
    TOKEN2,
    TOKEN_EOP,
    RCV_DATA,
    CHECK,
    DISCARD
  } rxpu_state_e;

  // Advance the CRC16 register by one byte, bit0 first as on the wire.
  function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc_in,
                                                  input logic [BYTE_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      fb = data[i] ^ c[CRC_W-1];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : CRC_W'(0));
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_crc16.sv
// CRC16 accumulator, byte-wide, LSB-first.
//   clk, rst : clock, synchronous active-high reset (loads init value)
//   clear    : reload the init value
//   enable   : fold data into the register
//   data     : byte to fold in
//   crc      : current register contents
module rx_crc16
  import usb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [BYTE_W-1:0] data,
  output logic [CRC_W-1:0]  crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= crc16_byte(crc, data);
    end
  end

endmodule

// File: rtl/rxpu.sv
// USB endpoint receive packet processor. Parses tokens addressed to this
// endpoint, answers IN tokens, and forwards armed DATA payloads to the RX FIFO
// with CRC16 validation.
//   inputs : clk, rst, pkt_start, byte_ready, rx_byte, eop, rx_error,
//            is_txing, tx_data_ready, fifo_full
//   outputs: fifo_w_enable, fifo_w_data, send_nak, send_data, pkt_good,
//            pkt_bad, rx_busy (all registered)
module rxpu
  import usb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'd1,
  parameter logic [3:0]  DEV_ENDP  = 4'd1,
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_start,
  input  logic       byte_ready,
  input  logic [7:0] rx_byte,
  input  logic       eop,
  input  logic       rx_error,
  input  logic       is_txing,
  input  logic       tx_data_ready,
  input  logic       fifo_full,
  output logic       fifo_w_enable,
  output logic [7:0] fifo_w_data,
  output logic       send_nak,
  output logic       send_data,
  output logic       pkt_good,
  output logic       pkt_bad,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

  rxpu_state_e state, state_d, mid_state;

  logic             out_armed, out_armed_d;
  logic             tok_is_in, tok_is_in_d;
  logic             tok_match, tok_match_d;
  logic             endp0, endp0_d;
  logic [7:0]       pipe_new, pipe_new_d;
  logic [7:0]       pipe_old, pipe_old_d;
  logic [1:0]       pipe_cnt, pipe_cnt_d;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_d;

  logic             fifo_w_enable_d;
  logic [7:0]       fifo_w_data_d;
  logic             send_nak_d, send_data_d, pkt_good_d, pkt_bad_d, rx_busy_d;

  logic             crc_clear_c, crc_en_c;
  logic [CRC_W-1:0] crc;

  rx_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (crc_clear_c),
    .enable (crc_en_c),
    .data   (rx_byte),
    .crc    (crc)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      out_armed     <= 1'b0;
      tok_is_in     <= 1'b0;
      tok_match     <= 1'b0;
      endp0         <= 1'b0;
      pipe_new      <= 8'd0;
      pipe_old      <= 8'd0;
      pipe_cnt      <= 2'd0;
      byte_cnt      <= '0;
      fifo_w_enable <= 1'b0;
      fifo_w_data   <= 8'd0;
      send_nak      <= 1'b0;
      send_data     <= 1'b0;
      pkt_good      <= 1'b0;
      pkt_bad       <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      state         <= state_d;
      out_armed     <= out_armed_d;
      tok_is_in     <= tok_is_in_d;
      tok_match     <= tok_match_d;
      endp0         <= endp0_d;
      pipe_new      <= pipe_new_d;
      pipe_old      <= pipe_old_d;
      pipe_cnt      <= pipe_cnt_d;
      byte_cnt      <= byte_cnt_d;
      fifo_w_enable <= fifo_w_enable_d;
      fifo_w_data   <= fifo_w_data_d;
      send_nak      <= send_nak_d;
      send_data     <= send_data_d;
      pkt_good      <= pkt_good_d;
      pkt_bad       <= pkt_bad_d;
      rx_busy       <= rx_busy_d;
    end
  end

  // Next state and outputs. A byte is handled first (mid_state), then eop is
  // applied to the state the byte produced.
  always_comb begin
    state_d         = state;
    mid_state       = state;
    out_armed_d     = out_armed;
    tok_is_in_d     = tok_is_in;
    tok_match_d     = tok_match;
    endp0_d         = endp0;
    pipe_new_d      = pipe_new;
    pipe_old_d      = pipe_old;
    pipe_cnt_d      = pipe_cnt;
    byte_cnt_d      = byte_cnt;
    fifo_w_enable_d = 1'b0;
    fifo_w_data_d   = fifo_w_data;
    send_nak_d      = 1'b0;
    send_data_d     = 1'b0;
    pkt_good_d      = 1'b0;
    pkt_bad_d       = 1'b0;
    crc_clear_c     = 1'b0;
    crc_en_c        = 1'b0;

    if (state == IDLE) begin
      if (pkt_start && !is_txing) state_d = RCV_PID;
    end else if (pkt_start) begin
      pkt_bad_d = 1'b1;
      state_d   = RCV_PID;
    end else if (rx_error && state != DISCARD) begin
      pkt_bad_d = 1'b1;
      state_d   = DISCARD;
    end else begin
      case (state)
        RCV_PID: if (byte_ready) begin
          case (rx_byte)
            PID_IN, PID_OUT: begin
              tok_is_in_d = (rx_byte == PID_IN);
              mid_state   = TOKEN1;
            end
            PID_DATA0, PID_DATA1: begin
              if (out_armed) begin
                crc_clear_c = 1'b1;
                pipe_cnt_d  = 2'd0;
                byte_cnt_d  = '0;
                mid_state   = RCV_DATA;
              end else begin
                pkt_bad_d = 1'b1;
                mid_state = DISCARD;
              end
            end
            default: begin
              pkt_bad_d = 1'b1;
              mid_state = DISCARD;
            end
          endcase
        end
        TOKEN1: if (byte_ready) begin
          tok_match_d = (rx_byte[6:0] == DEV_ADDR);
          endp0_d     = rx_byte[7];
          mid_state   = TOKEN2;
        end
        TOKEN2: if (byte_ready) begin
          tok_match_d = tok_match && ({rx_byte[2:0], endp0} == DEV_ENDP);
          mid_state   = TOKEN_EOP;
        end
        RCV_DATA: if (byte_ready) begin
          crc_en_c   = 1'b1;
          pipe_new_d = rx_byte;
          pipe_old_d = pipe_new;
          // Oldest byte leaves the 2-deep pipe; the last two bytes (CRC) stay.
          if (pipe_cnt == 2'd2) begin
            if (fifo_full || byte_cnt == CNT_W'(MAX_BYTES)) begin
              pkt_bad_d = 1'b1;
              mid_state = DISCARD;
            end else begin
              fifo_w_enable_d = 1'b1;
              fifo_w_data_d   = pipe_old;
              byte_cnt_d      = byte_cnt + CNT_W'(1);
            end
          end else begin
            pipe_cnt_d = pipe_cnt + 2'd1;
          end
        end
        CHECK: begin
          if (crc == CRC_RESIDUE && pipe_cnt == 2'd2) pkt_good_d = 1'b1;
          else                                         pkt_bad_d  = 1'b1;
          out_armed_d = 1'b0;
          mid_state   = IDLE;
        end
        default: ;
      endcase

      state_d = mid_state;
      if (eop) begin
        case (mid_state)
          RCV_PID, TOKEN1, TOKEN2: begin
            pkt_bad_d = 1'b1;
            state_d   = IDLE;
          end
          TOKEN_EOP: begin
            if (tok_match_d) begin
              if (tok_is_in_d) begin
                send_data_d = tx_data_ready;
                send_nak_d  = !tx_data_ready;
              end else begin
                out_armed_d = 1'b1;
              end
            end
            state_d = IDLE;
          end
          RCV_DATA: state_d = CHECK;
          DISCARD: begin
            out_armed_d = 1'b0;
            state_d     = IDLE;
          end
          default: ;
        endcase
      end
    end

    rx_busy_d = (state_d != IDLE);
  end

endmodule
